// File: rtl/sap_control_sequencer_if.sv
// SAP-U control bus between the sequencer (master) and the datapath (slave).
// Build option SAP_CTRL_FLAGS_EN adds carry/zero flag inputs and the flags_load strobe.
interface sap_control_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_bus;
  logic [DATA_WIDTH-1:0] ir_bus_out;
  logic                  ir_bus_enable_n;
  logic                  reg_a_load_n;
  logic                  reg_a_bus_enable_n;
  logic                  reg_b_load_n;
  logic                  alu_enable_n;
  logic                  alu_subtract;
  logic                  ram_bus_enable_n;
  logic                  ram_write_enable_n;
  logic                  ram_load_mar_reg_n;
  logic                  ram_clear_mar_reg;
  logic                  program_counter_clear_n;
  logic                  program_counter_enable;
  logic                  program_counter_bus_enable_n;
  logic                  jump_n;
  logic [DATA_WIDTH-1:0] out_value;
  logic                  out_valid;
  logic                  halted;
`ifdef SAP_CTRL_FLAGS_EN
  logic                  carry_flag;
  logic                  zero_flag;
  logic                  flags_load;
`endif

  modport master (
    input  data_bus,
`ifdef SAP_CTRL_FLAGS_EN
    input  carry_flag, zero_flag,
    output flags_load,
`endif
    output ir_bus_out, ir_bus_enable_n, reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n,
    output alu_enable_n, alu_subtract, ram_bus_enable_n, ram_write_enable_n, ram_load_mar_reg_n,
    output ram_clear_mar_reg, program_counter_clear_n, program_counter_enable,
    output program_counter_bus_enable_n, jump_n, out_value, out_valid, halted
  );

  modport slave (
    output data_bus,
`ifdef SAP_CTRL_FLAGS_EN
    output carry_flag, zero_flag,
    input  flags_load,
`endif
    input  ir_bus_out, ir_bus_enable_n, reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n,
    input  alu_enable_n, alu_subtract, ram_bus_enable_n, ram_write_enable_n, ram_load_mar_reg_n,
    input  ram_clear_mar_reg, program_counter_clear_n, program_counter_enable,
    input  program_counter_bus_enable_n, jump_n, out_value, out_valid, halted
  );
endinterface

// File: rtl/sap_control_sequencer.sv
// SAP-U microcoded sequencer: fetch in T0-T1, execute up to T4; controls are combinational from state.
// run=0 or halted freezes state with idle controls; SAP_CTRL_FLAGS_EN adds JC/JZ and flags_load.
module sap_control_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  sap_control_sequencer_if.master bus
);

  typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_t;

  typedef struct packed {
    logic ir_bus_enable_n;
    logic reg_a_load_n;
    logic reg_a_bus_enable_n;
    logic reg_b_load_n;
    logic alu_enable_n;
    logic alu_subtract;
    logic ram_bus_enable_n;
    logic ram_write_enable_n;
    logic ram_load_mar_reg_n;
    logic program_counter_enable;
    logic program_counter_bus_enable_n;
    logic jump_n;
`ifdef SAP_CTRL_FLAGS_EN
    logic flags_load;
`endif
  } ctrl_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  step_t                 step_q, step_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic                  halted_q, halted_d;
  logic [DATA_WIDTH-1:0] out_value_q, out_value_d;
  logic                  out_valid_q, out_valid_d;
  logic [3:0]            cur_op, fetch_op, op_now;
  logic                  active;
  ctrl_t                 ctrl;

  assign cur_op   = ir_q[DATA_WIDTH-1 -: 4];
  assign fetch_op = bus.data_bus[DATA_WIDTH-1 -: 4];

  // Final T-state of each opcode; unknown opcodes behave as NOP and end after fetch.
  function automatic step_t last_step(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA:                 last_step = T3;
      OP_ADD, OP_SUB:                 last_step = T4;
      OP_LDI, OP_JMP, OP_OUT, OP_HLT: last_step = T2;
`ifdef SAP_CTRL_FLAGS_EN
      OP_JC, OP_JZ:                   last_step = T2;
`endif
      default:                        last_step = T1;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q      <= T0;
      ir_q        <= '0;
      halted_q    <= 1'b0;
      out_value_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      step_q      <= step_d;
      ir_q        <= ir_d;
      halted_q    <= halted_d;
      out_value_q <= out_value_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    step_d      = step_q;
    ir_d        = ir_q;
    halted_d    = halted_q;
    out_value_d = out_value_q;
    out_valid_d = 1'b0;
    ctrl                        = '1;
    ctrl.alu_subtract           = 1'b0;
    ctrl.program_counter_enable = 1'b0;
`ifdef SAP_CTRL_FLAGS_EN
    ctrl.flags_load             = 1'b0;
`endif
    // During T1 the opcode is still on the bus, not yet in IR.
    op_now = (step_q == T1) ? fetch_op : cur_op;
    active = run && !halted_q && !reset;

    if (active) begin
      step_d = (step_q == last_step(op_now)) ? T0 : step_t'(step_q + 3'd1);
      case (step_q)
        T0: begin
          ctrl.program_counter_bus_enable_n = 1'b0;
          ctrl.ram_load_mar_reg_n           = 1'b0;
        end
        T1: begin
          ctrl.ram_bus_enable_n       = 1'b0;
          ctrl.program_counter_enable = 1'b1;
          ir_d                        = bus.data_bus;
        end
        T2: begin
          case (cur_op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ctrl.ir_bus_enable_n    = 1'b0;
              ctrl.ram_load_mar_reg_n = 1'b0;
            end
            OP_LDI: begin
              ctrl.ir_bus_enable_n = 1'b0;
              ctrl.reg_a_load_n    = 1'b0;
            end
            OP_JMP: begin
              ctrl.ir_bus_enable_n = 1'b0;
              ctrl.jump_n          = 1'b0;
            end
`ifdef SAP_CTRL_FLAGS_EN
            OP_JC: begin
              ctrl.ir_bus_enable_n = 1'b0;
              ctrl.jump_n          = ~bus.carry_flag;
            end
            OP_JZ: begin
              ctrl.ir_bus_enable_n = 1'b0;
              ctrl.jump_n          = ~bus.zero_flag;
            end
`endif
            OP_OUT: begin
              ctrl.reg_a_bus_enable_n = 1'b0;
              out_value_d             = bus.data_bus;
              out_valid_d             = 1'b1;
            end
            OP_HLT:  halted_d = 1'b1;
            default: ;
          endcase
        end
        T3: begin
          case (cur_op)
            OP_LDA: begin
              ctrl.ram_bus_enable_n = 1'b0;
              ctrl.reg_a_load_n     = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              ctrl.ram_bus_enable_n = 1'b0;
              ctrl.reg_b_load_n     = 1'b0;
            end
            OP_STA: begin
              ctrl.reg_a_bus_enable_n = 1'b0;
              ctrl.ram_write_enable_n = 1'b0;
            end
            default: ;
          endcase
        end
        T4: begin
          ctrl.alu_enable_n = 1'b0;
          ctrl.reg_a_load_n = 1'b0;
          ctrl.alu_subtract = (cur_op == OP_SUB);
`ifdef SAP_CTRL_FLAGS_EN
          ctrl.flags_load   = 1'b1;
`endif
        end
        default: step_d = T0;
      endcase
    end
  end

  assign bus.ir_bus_out                   = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, ir_q[ADDR_WIDTH-1:0]};
  assign bus.ir_bus_enable_n              = ctrl.ir_bus_enable_n;
  assign bus.reg_a_load_n                 = ctrl.reg_a_load_n;
  assign bus.reg_a_bus_enable_n           = ctrl.reg_a_bus_enable_n;
  assign bus.reg_b_load_n                 = ctrl.reg_b_load_n;
  assign bus.alu_enable_n                 = ctrl.alu_enable_n;
  assign bus.alu_subtract                 = ctrl.alu_subtract;
  assign bus.ram_bus_enable_n             = ctrl.ram_bus_enable_n;
  assign bus.ram_write_enable_n           = ctrl.ram_write_enable_n;
  assign bus.ram_load_mar_reg_n           = ctrl.ram_load_mar_reg_n;
  assign bus.ram_clear_mar_reg            = reset;
  assign bus.program_counter_clear_n      = ~reset;
  assign bus.program_counter_enable       = ctrl.program_counter_enable;
  assign bus.program_counter_bus_enable_n = ctrl.program_counter_bus_enable_n;
  assign bus.jump_n                       = ctrl.jump_n;
  assign bus.out_value                    = out_value_q;
  assign bus.out_valid                    = out_valid_q;
  assign bus.halted                       = halted_q;
`ifdef SAP_CTRL_FLAGS_EN
  assign bus.flags_load                   = ctrl.flags_load;
`endif

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Bench for sap_control_sequencer: directed program steps then random traffic against an instruction-level model.
module tb_sap_control_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic run;
  int   total = 0;
  int   bad   = 0;

  sap_control_sequencer_if #(.DATA_WIDTH(8)) bus_if();

  sap_control_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Control word: each bit flips from its idle level when the strobe is asserted.
  localparam logic [11:0] IDLE   = 12'hFBB;
  localparam logic [11:0] M_IR   = 12'h800;
  localparam logic [11:0] M_AL   = 12'h400;
  localparam logic [11:0] M_AB   = 12'h200;
  localparam logic [11:0] M_BL   = 12'h100;
  localparam logic [11:0] M_ALU  = 12'h080;
  localparam logic [11:0] M_SUB  = 12'h040;
  localparam logic [11:0] M_RB   = 12'h020;
  localparam logic [11:0] M_WE   = 12'h010;
  localparam logic [11:0] M_MAR  = 12'h008;
  localparam logic [11:0] M_PCEN = 12'h004;
  localparam logic [11:0] M_PCB  = 12'h002;
  localparam logic [11:0] M_J    = 12'h001;

  logic [11:0] obs_ctl;
  assign obs_ctl = {bus_if.ir_bus_enable_n, bus_if.reg_a_load_n, bus_if.reg_a_bus_enable_n,
                    bus_if.reg_b_load_n, bus_if.alu_enable_n, bus_if.alu_subtract,
                    bus_if.ram_bus_enable_n, bus_if.ram_write_enable_n, bus_if.ram_load_mar_reg_n,
                    bus_if.program_counter_enable, bus_if.program_counter_bus_enable_n, bus_if.jump_n};

`ifdef SAP_CTRL_FLAGS_EN
  logic carry_v = 1'b0;
  logic zero_v  = 1'b0;
`endif

  // Model state: cycle index within the current instruction plus architectural registers.
  bit         m_valid = 1'b0;
  int         m_k     = 0;
  logic [7:0] m_ir    = 8'h00;
  bit         m_halt  = 1'b0;
  logic [7:0] m_out   = 8'h00;
  bit         m_outv  = 1'b0;

  function automatic int ilen(input logic [3:0] op);
    case (op)
      4'h1, 4'h4:             return 4;
      4'h2, 4'h3:             return 5;
      4'h5, 4'h6, 4'hE, 4'hF: return 3;
`ifdef SAP_CTRL_FLAGS_EN
      4'h7, 4'h8:             return 3;
`endif
      default:                return 2;
    endcase
  endfunction

  function automatic logic [11:0] strobes(input logic [3:0] op, input int k);
    logic [11:0] m;
    m = '0;
    if (k == 0) m = M_PCB | M_MAR;
    else if (k == 1) m = M_RB | M_PCEN;
    else if (k == 2) begin
      case (op)
        4'h1, 4'h2, 4'h3, 4'h4: m = M_IR | M_MAR;
        4'h5: m = M_IR | M_AL;
        4'h6: m = M_IR | M_J;
`ifdef SAP_CTRL_FLAGS_EN
        4'h7: m = M_IR | (carry_v ? M_J : 12'h000);
        4'h8: m = M_IR | (zero_v ? M_J : 12'h000);
`endif
        4'hE: m = M_AB;
        default: m = '0;
      endcase
    end else if (k == 3) begin
      case (op)
        4'h1:       m = M_RB | M_AL;
        4'h2, 4'h3: m = M_RB | M_BL;
        4'h4:       m = M_AB | M_WE;
        default:    m = '0;
      endcase
    end else if (k == 4) m = M_ALU | M_AL | ((op == 4'h3) ? M_SUB : 12'h000);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (k=%0d ir=%h)", tag, obs, exp, m_k, m_ir);
    end
  endtask

  // One clock: apply inputs, compare at the falling edge, advance the model, return after the rising edge.
  task automatic cyc(input logic r_rst, input logic r_run, input logic [7:0] d);
    logic [3:0] op;
    bit         act;
    reset          = r_rst;
    run            = r_run;
    bus_if.data_bus = d;
`ifdef SAP_CTRL_FLAGS_EN
    bus_if.carry_flag = carry_v;
    bus_if.zero_flag  = zero_v;
`endif
    @(negedge clk);
    op  = (m_k == 1) ? d[7:4] : m_ir[7:4];
    act = !r_rst && r_run && !m_halt;
    if (m_valid) begin
      chk("controls", obs_ctl, act ? (IDLE ^ strobes(op, m_k)) : IDLE);
      chk("ir_bus_out", {4'h0, bus_if.ir_bus_out}, {8'h00, m_ir[3:0]});
      chk("out_value", {4'h0, bus_if.out_value}, {4'h0, m_out});
      chk("out_valid", {11'h0, bus_if.out_valid}, {11'h0, m_outv});
      chk("halted", {11'h0, bus_if.halted}, {11'h0, m_halt});
      chk("mar_clear", {11'h0, bus_if.ram_clear_mar_reg}, {11'h0, r_rst});
      chk("pc_clear_n", {11'h0, bus_if.program_counter_clear_n}, {11'h0, !r_rst});
`ifdef SAP_CTRL_FLAGS_EN
      chk("flags_load", {11'h0, bus_if.flags_load},
          {11'h0, act && m_k == 4 && (op == 4'h2 || op == 4'h3)});
`endif
    end
    if (r_rst) begin
      m_valid = 1'b1;
      m_k     = 0;
      m_ir    = 8'h00;
      m_halt  = 1'b0;
      m_out   = 8'h00;
      m_outv  = 1'b0;
    end else if (m_valid) begin
      m_outv = 1'b0;
      if (r_run && !m_halt) begin
        if (m_k == 1) m_ir = d;
        if (m_k == 2 && m_ir[7:4] == 4'hE) begin
          m_out  = d;
          m_outv = 1'b1;
        end
        if (m_k == 2 && m_ir[7:4] == 4'hF) m_halt = 1'b1;
        m_k = (m_k + 1 >= ilen(m_ir[7:4])) ? 0 : m_k + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [7:0] ins, input logic [7:0] d2);
    int len;
    len = ilen(ins[7:4]);
    cyc(1'b0, 1'b1, 8'($urandom));
    cyc(1'b0, 1'b1, ins);
    for (int k = 2; k < len; k++) cyc(1'b0, 1'b1, (k == 2) ? d2 : 8'($urandom));
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b1;
    bus_if.data_bus = 8'h00;
`ifdef SAP_CTRL_FLAGS_EN
    bus_if.carry_flag = 1'b0;
    bus_if.zero_flag  = 1'b0;
`endif
    #1;
    cyc(1'b1, 1'b1, 8'h00);
    cyc(1'b1, 1'b1, 8'hA5);

    instr(8'h1E, 8'h77);
    instr(8'h2F, 8'h11);
    instr(8'h3F, 8'h22);
    instr(8'h63, 8'h33);
    instr(8'hE0, 8'h5A);
    instr(8'h00, 8'h00);
    instr(8'h5C, 8'h44);
    instr(8'h4B, 8'h55);
    instr(8'h9D, 8'h66);

    instr(8'hF0, 8'h12);
    repeat (20) cyc(1'b0, 1'b1, 8'($urandom));
    cyc(1'b1, 1'b1, 8'h34);
    instr(8'h00, 8'h00);

    cyc(1'b0, 1'b1, 8'h01);
    cyc(1'b0, 1'b1, 8'h25);
    cyc(1'b0, 1'b1, 8'h02);
    cyc(1'b1, 1'b1, 8'h03);
    instr(8'h17, 8'h00);

    cyc(1'b0, 1'b1, 8'h01);
    cyc(1'b0, 1'b1, 8'h47);
    cyc(1'b0, 1'b1, 8'h02);
    repeat (5) cyc(1'b0, 1'b0, 8'($urandom));
    cyc(1'b0, 1'b1, 8'h03);
    instr(8'h00, 8'h00);

`ifdef SAP_CTRL_FLAGS_EN
    carry_v = 1'b1;
    instr(8'h75, 8'h00);
    carry_v = 1'b0;
    instr(8'h75, 8'h00);
    zero_v = 1'b1;
    instr(8'h82, 8'h00);
`endif

    for (int i = 0; i < 2000; i++) begin
`ifdef SAP_CTRL_FLAGS_EN
      carry_v = 1'($urandom);
      zero_v  = 1'($urandom);
`endif
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) != 0), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
